// File: rtl/cel_unpack_sequencer_if.sv
// Pixel stream from the cel unpack sequencer toward the cel pixel processor.
// A beat transfers on a clock edge where pix_valid && pix_ready; while pix_valid is
// high and pix_ready low the master holds pix_col/pix_x/pix_y stable.
interface cel_unpack_sequencer_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          pix_valid;
  logic          pix_ready;
  logic [15:0]   pix_col;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  modport master (output pix_valid, pix_col, pix_x, pix_y, input pix_ready);
  modport slave  (input pix_valid, pix_col, pix_x, pix_y, output pix_ready);
endinterface

// File: rtl/cel_unpack_sequencer.sv
// Drives the packed-cel unpacker through one cel, drops skipx leading pixels per row,
// tags kept pixels with (x, y) and buffers them in a small FIFO.
module cel_unpack_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int XW         = 11,
  parameter int YW         = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic [31:0]            sourceptr,
  input  logic [2:0]             bpp,
  input  logic [3:0]             skipx,
  input  logic [YW-1:0]          vcnt,
  output logic                   busy,
  output logic                   done,
  output logic                   err_bpp,
  output logic                   err_ovf,
  output logic                   up_rst_n,
  output logic                   up_start,
  output logic [31:0]            up_sourceptr,
  output logic [2:0]             up_bpp,
  output logic [3:0]             up_skipx,
  input  logic                   up_pix_valid,
  input  logic [15:0]            up_col,
  input  logic                   up_eol,
  cel_unpack_sequencer_if.master pix,
  output logic [2:0]             dbg_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = 16 + XW + YW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UPRST = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   src_q, src_d;
  logic [2:0]    bpp_q, bpp_d;
  logic [3:0]    skipx_q, skipx_d;
  logic [YW-1:0] vcnt_q, vcnt_d;
  logic [XW-1:0] xraw_q, xraw_d;
  logic [YW-1:0] y_q, y_d;
  logic          err_bpp_q, err_bpp_d;
  logic          err_ovf_q, err_ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] mem_q [FIFO_DEPTH];

  logic          push_en;
  logic          pop;
  logic          full;
  logic [XW-1:0] x_tag;
  logic [PW-1:0] push_data;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    bpp_d     = bpp_q;
    skipx_d   = skipx_q;
    vcnt_d    = vcnt_q;
    xraw_d    = xraw_q;
    y_d       = y_q;
    err_bpp_d = err_bpp_q;
    err_ovf_d = err_ovf_q;
    push_en   = 1'b0;
    pop       = (count_q != '0) && pix.pix_ready;
    full      = (count_q == CW'(FIFO_DEPTH));
    x_tag     = xraw_q - XW'(skipx_q);
    push_data = {up_col, x_tag, y_q};

    case (state_q)
      S_IDLE: begin
        if (go) begin
          src_d     = sourceptr;
          bpp_d     = bpp;
          skipx_d   = skipx;
          vcnt_d    = vcnt;
          xraw_d    = '0;
          y_d       = '0;
          err_ovf_d = 1'b0;
          if (bpp == 3'd0 || bpp == 3'd7) begin
            err_bpp_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            err_bpp_d = 1'b0;
            state_d   = S_UPRST;
          end
        end
      end
      S_UPRST: state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        // Pixel uses the old x/y; a same-cycle EOL then overrides the x increment.
        if (up_pix_valid) begin
          if (xraw_q >= XW'(skipx_q)) begin
            if (!full || pop) push_en = 1'b1;
            else              err_ovf_d = 1'b1;
          end
          if (xraw_q != '1) xraw_d = xraw_q + 1'b1;
        end
        if (up_eol) begin
          if (y_q == vcnt_q) begin
            state_d = S_DRAIN;
          end else begin
            y_d    = y_q + 1'b1;
            xraw_d = '0;
          end
        end
      end
      S_DRAIN: if (count_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_en) - CW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      bpp_q     <= '0;
      skipx_q   <= '0;
      vcnt_q    <= '0;
      xraw_q    <= '0;
      y_q       <= '0;
      err_bpp_q <= 1'b0;
      err_ovf_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      bpp_q     <= bpp_d;
      skipx_q   <= skipx_d;
      vcnt_q    <= vcnt_d;
      xraw_q    <= xraw_d;
      y_q       <= y_d;
      err_bpp_q <= err_bpp_d;
      err_ovf_q <= err_ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is visible.
  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err_bpp       = err_bpp_q;
  assign err_ovf       = err_ovf_q;
  assign up_rst_n      = (state_q == S_START) || (state_q == S_RUN);
  assign up_start      = (state_q == S_START);
  assign up_sourceptr  = src_q;
  assign up_bpp        = bpp_q;
  assign up_skipx      = skipx_q;
  assign pix.pix_valid = (count_q != '0);
  assign {pix.pix_col, pix.pix_x, pix.pix_y} = mem_q[rd_ptr_q];
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_cel_unpack_sequencer.sv
// Self-checking bench for cel_unpack_sequencer: a behavioural unpacker driver, a pixel
// scoreboard fed from a per-row reference model, and directed plus random scenarios.
module tb_cel_unpack_sequencer;
  localparam int FIFO_DEPTH = 8;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int PW = 16 + XW + YW;

  logic          clock = 1'b0;
  logic          reset;
  logic          go;
  logic [31:0]   sourceptr;
  logic [2:0]    bpp;
  logic [3:0]    skipx;
  logic [YW-1:0] vcnt;
  logic          busy, done, err_bpp, err_ovf, up_rst_n, up_start;
  logic [31:0]   up_sourceptr;
  logic [2:0]    up_bpp;
  logic [3:0]    up_skipx;
  logic          up_pix_valid;
  logic [15:0]   up_col;
  logic          up_eol;
  logic [2:0]    dbg_state;

  cel_unpack_sequencer_if #(.XW(XW), .YW(YW)) ifc ();

  cel_unpack_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .XW(XW), .YW(YW)) dut (
    .clock(clock), .reset(reset), .go(go), .sourceptr(sourceptr), .bpp(bpp),
    .skipx(skipx), .vcnt(vcnt), .busy(busy), .done(done), .err_bpp(err_bpp),
    .err_ovf(err_ovf), .up_rst_n(up_rst_n), .up_start(up_start),
    .up_sourceptr(up_sourceptr), .up_bpp(up_bpp), .up_skipx(up_skipx),
    .up_pix_valid(up_pix_valid), .up_col(up_col), .up_eol(up_eol),
    .pix(ifc.master), .dbg_state(dbg_state)
  );

  // Clock/reset and cycle counter
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] obs_q[$];
  int done_cnt = 0, done_cyc = 0, start_cnt = 0, start_cyc = 0, rstn_cnt = 0, last_pop_cyc = 0;
  logic [15:0] row_vals [16];
  bit rand_ready = 0;
  int go_cyc;

  // Monitor: records pops and control pulses mid-cycle
  always @(negedge clock) begin
    if (!reset) begin
      if (ifc.pix_valid && ifc.pix_ready) begin
        obs_q.push_back({ifc.pix_col, ifc.pix_x, ifc.pix_y});
        last_pop_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (up_start) begin start_cnt++; start_cyc = cyc; end
      if (up_rst_n) rstn_cnt++;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clock); #1;
    if (rand_ready) ifc.pix_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_go(input logic [31:0] s, input logic [2:0] b, input logic [3:0] k,
                       input logic [YW-1:0] v);
    sourceptr = s; bpp = b; skipx = k; vcnt = v; go = 1'b1;
    go_cyc = cyc;
    step();
    go = 1'b0;
  endtask

  task automatic wait_start();
    int base = start_cnt;
    for (int i = 0; i < 20; i++) begin
      if (start_cnt != base) break;
      step();
    end
  endtask

  task automatic wait_done(input int base, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_cnt != base) break;
      step();
    end
  endtask

  task automatic emit_row(input int n, input bit combine, input int gap_max);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) step();
      up_pix_valid = 1'b1;
      up_col = row_vals[i];
      up_eol = combine && (i == n - 1);
      step();
      up_pix_valid = 1'b0;
      up_eol = 1'b0;
    end
    if (!combine || n == 0) begin
      up_eol = 1'b1;
      step();
      up_eol = 1'b0;
    end
  endtask

  // Reference model: kept pixel i of row r lands at x = i - skip, y = r
  task automatic model_row(input int r, input int n, input int skip);
    for (int i = 0; i < n; i++)
      if (i >= skip) exp_q.push_back({row_vals[i], XW'(i - skip), YW'(r)});
  endtask

  task automatic fill_row_random(input int n);
    for (int i = 0; i < n; i++) row_vals[i] = 16'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({err_bpp, err_ovf} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {err_bpp, err_ovf}); end
    checks++; if ({up_rst_n, up_start} !== 2'b00) begin errors++; $display("FAIL reset_up got=%b exp=00", {up_rst_n, up_start}); end
    checks++; if (ifc.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got=%b exp=0", ifc.pix_valid); end
    checks++; if ({up_sourceptr, up_bpp, up_skipx} !== 39'd0) begin errors++; $display("FAIL reset_cfg got=%h exp=0", {up_sourceptr, up_bpp, up_skipx}); end
    reset = 1'b0;
    step();
  endtask

  task automatic compare_pixels(input string name, input int obs_base);
    checks++;
    if (obs_q.size() - obs_base !== exp_q.size()) begin
      errors++; $display("FAIL %s_count got=%0d exp=%0d", name, obs_q.size() - obs_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[obs_base + i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_pix%0d got=%h exp=%h", name, i, obs_q[obs_base + i], exp_q[i]);
      end
    end
  endtask

  task automatic test_basic();
    int ob = obs_q.size(); int db = done_cnt;
    exp_q.delete();
    ifc.pix_ready = 1'b1;
    do_go(32'h1234_5678, 3'd5, 4'd0, YW'(1));
    wait_start();
    checks++; if (start_cyc - go_cyc !== 2) begin errors++; $display("FAIL basic_start_latency got=%0d exp=2", start_cyc - go_cyc); end
    step();
    for (int r = 0; r < 2; r++) begin
      fill_row_random(3); model_row(r, 3, 0); emit_row(3, 0, 1);
    end
    wait_done(db, 50);
    repeat (2) step();
    compare_pixels("basic", ob);
    checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - db); end
    checks++; if ({up_rst_n, busy} !== 2'b00) begin errors++; $display("FAIL basic_after got=%b exp=00", {up_rst_n, busy}); end
  endtask

  task automatic test_skip();
    int ob = obs_q.size(); int db = done_cnt;
    exp_q.delete();
    exp_q.push_back({16'h0012, XW'(0), YW'(0)});
    exp_q.push_back({16'h0013, XW'(1), YW'(0)});
    exp_q.push_back({16'h0014, XW'(2), YW'(0)});
    ifc.pix_ready = 1'b1;
    do_go(32'h0000_0100, 3'd3, 4'd2, YW'(0));
    wait_start(); step();
    for (int i = 0; i < 5; i++) row_vals[i] = 16'h0010 + 16'(i);
    emit_row(5, 0, 2);
    wait_done(db, 50);
    compare_pixels("skip", ob);
    checks++; if (up_skipx !== 4'd2) begin errors++; $display("FAIL skip_cfg got=%0d exp=2", up_skipx); end
  endtask

  task automatic test_overflow();
    int ob = obs_q.size(); int db = done_cnt;
    logic [PW-1:0] head;
    exp_q.delete();
    ifc.pix_ready = 1'b0;
    do_go(32'hA000_0000, 3'd6, 4'd0, YW'(0));
    wait_start(); step();
    fill_row_random(10);
    model_row(0, FIFO_DEPTH, 0);
    emit_row(10, 0, 0);
    repeat (3) step();
    @(negedge clock);
    head = {ifc.pix_col, ifc.pix_x, ifc.pix_y};
    checks++; if ({ifc.pix_valid, err_ovf} !== 2'b11) begin errors++; $display("FAIL ovf_flags got=%b exp=11", {ifc.pix_valid, err_ovf}); end
    checks++; if (done_cnt - db !== 0) begin errors++; $display("FAIL ovf_early_done got=%0d exp=0", done_cnt - db); end
    step(); @(negedge clock);
    checks++; if ({ifc.pix_col, ifc.pix_x, ifc.pix_y} !== head) begin errors++; $display("FAIL ovf_head_stable got=%h exp=%h", {ifc.pix_col, ifc.pix_x, ifc.pix_y}, head); end
    step();
    ifc.pix_ready = 1'b1;
    wait_done(db, 50);
    compare_pixels("ovf", ob);
    checks++; if (!(done_cnt - db == 1 && done_cyc > last_pop_cyc)) begin errors++; $display("FAIL ovf_done_after_pop got=%0d/%0d exp_done_after=%0d", done_cnt - db, done_cyc, last_pop_cyc); end
  endtask

  task automatic test_bad_bpp(input logic [2:0] b);
    int db = done_cnt; int sb = start_cnt; int rb = rstn_cnt;
    do_go(32'hDEAD_BEEF, b, 4'd1, YW'(3));
    wait_done(db, 10);
    checks++; if (!(done_cnt - db == 1 && done_cyc - go_cyc >= 1 && done_cyc - go_cyc <= 2)) begin errors++; $display("FAIL badbpp%0d_done got=%0d@%0d exp=1@1..2", b, done_cnt - db, done_cyc - go_cyc); end
    checks++; if (err_bpp !== 1'b1) begin errors++; $display("FAIL badbpp%0d_err got=%b exp=1", b, err_bpp); end
    repeat (3) step();
    checks++; if (start_cnt - sb !== 0 || rstn_cnt - rb !== 0) begin errors++; $display("FAIL badbpp%0d_up got=%0d/%0d exp=0/0", b, start_cnt - sb, rstn_cnt - rb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badbpp%0d_busy got=%b exp=0", b, busy); end
  endtask

  task automatic test_go_ignored_and_reset();
    int ob = obs_q.size(); int db = done_cnt;
    exp_q.delete();
    ifc.pix_ready = 1'b1;
    do_go(32'h5555_0000, 3'd2, 4'd1, YW'(1));
    wait_start(); step();
    fill_row_random(4); model_row(0, 4, 1); emit_row(4, 0, 1);
    do_go(32'h9999_9999, 3'd4, 4'd7, YW'(5));
    checks++; if ({up_sourceptr, up_bpp, up_skipx} !== {32'h5555_0000, 3'd2, 4'd1}) begin errors++; $display("FAIL goign_cfg got=%h exp=%h", {up_sourceptr, up_bpp, up_skipx}, {32'h5555_0000, 3'd2, 4'd1}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL goign_busy got=%b exp=1", busy); end
    fill_row_random(3); model_row(1, 3, 1); emit_row(3, 0, 1);
    wait_done(db, 50);
    compare_pixels("goign", ob);
    // Mid-RUN reset
    db = done_cnt;
    ifc.pix_ready = 1'b0;
    do_go(32'h7777_0000, 3'd5, 4'd0, YW'(2));
    wait_start(); step();
    fill_row_random(3); emit_row(3, 0, 0);
    reset = 1'b1;
    step();
    checks++; if ({busy, ifc.pix_valid, up_rst_n, dbg_state} !== 6'b000_000) begin errors++; $display("FAIL midreset_state got=%b exp=000000", {busy, ifc.pix_valid, up_rst_n, dbg_state}); end
    reset = 1'b0;
    repeat (5) step();
    checks++; if (done_cnt - db !== 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_nodone got=%0d/%b exp=0/0", done_cnt - db, busy); end
  endtask

  task automatic test_same_cycle();
    int ob = obs_q.size(); int db = done_cnt;
    exp_q.delete();
    ifc.pix_ready = 1'b1;
    do_go(32'h0000_4000, 3'd1, 4'd0, YW'(1));
    wait_start(); step();
    fill_row_random(3); model_row(0, 3, 0); emit_row(3, 1, 0);
    fill_row_random(2); model_row(1, 2, 0); emit_row(2, 1, 1);
    wait_done(db, 50);
    compare_pixels("samecyc", ob);
  endtask

  task automatic test_random();
    for (int c = 0; c < 4; c++) begin
      int ob = obs_q.size(); int db = done_cnt;
      int k = $urandom_range(0, 3);
      int nv = $urandom_range(0, 2);
      exp_q.delete();
      rand_ready = 1;
      do_go($urandom, 3'($urandom_range(1, 6)), 4'(k), YW'(nv));
      wait_start(); step();
      for (int r = 0; r <= nv; r++) begin
        int n = $urandom_range(1, 6);
        bit cmb = 1'($urandom_range(0, 1));
        fill_row_random(n); model_row(r, n, k); emit_row(n, cmb, 1);
      end
      wait_done(db, 200);
      rand_ready = 0;
      ifc.pix_ready = 1'b1;
      compare_pixels("random", ob);
      checks++; if (done_cnt - db !== 1 || err_ovf !== 1'b0) begin errors++; $display("FAIL random_done got=%0d/%b exp=1/0", done_cnt - db, err_ovf); end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; sourceptr = '0; bpp = '0; skipx = '0; vcnt = '0;
    up_pix_valid = 1'b0; up_col = '0; up_eol = 1'b0; ifc.pix_ready = 1'b0;
    test_reset();
    test_basic();
    test_skip();
    test_overflow();
    test_bad_bpp(3'd7);
    test_bad_bpp(3'd0);
    test_go_ignored_and_reset();
    test_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
